// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants for the serial adder scheduler.
// Optional subtract support is enabled with the SERIAL_ADD_SUB_EN macro.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/serial_add_dp.sv
// serial_add_dp: bit-serial add datapath. Operands shift out LSB first, each
// sum bit shifts in at the result MSB, so after WIDTH enabled cycles the
// result register holds the full sum and the carry register the carry-out.
// invert_b/cin_init let the scheduler turn an add into a subtract
// (SERIAL_ADD_SUB_EN builds only).
module serial_add_dp
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic             cin_init,
  input  logic             invert_b,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             b_bit;
  logic             sum_bit;

  // Full adder on the operand LSBs plus held carry; load restarts an operation.
  always_comb begin
    b_bit   = b_q[0] ^ invert_b;
    sum_bit = a_q[0] ^ b_bit ^ carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    if (load) begin
      a_d     = a_in;
      b_d     = b_in;
      res_d   = '0;
      carry_d = cin_init;
    end else if (enable) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      res_d   = {sum_bit, res_q[WIDTH-1:1]};
      carry_d = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);
    end
  end

  // Datapath registers; cleared on reset so the response reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  assign result = res_q;
  assign carry  = carry_q;

endmodule

// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin arbiter and sequencer in front of one shared
// bit-serial adder. Accepts one operation in IDLE, runs WIDTH shift cycles,
// then holds the result on the rsp port until it is taken.
// Define SERIAL_ADD_SUB_EN to add per-requester subtract inputs.
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             req0_sub,
  input  logic             req1_sub,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_t          last_q, last_d;
  req_id_t          id_q, id_d;
  logic             grant0, grant1;
  logic             accept;
  logic             dp_load, dp_en, dp_cin, dp_inv;
  logic [WIDTH-1:0] dp_a, dp_b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q, sub_d;
`endif

  // Arbiter: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_q);
    grant1     = req1_valid & (~req0_valid | ~last_q);
    req0_ready = (state_q == IDLE) & grant0 & ~rst;
    req1_ready = (state_q == IDLE) & grant1 & ~rst;
    accept     = req0_ready | req1_ready;
    dp_a       = grant1 ? req1_a : req0_a;
    dp_b       = grant1 ? req1_b : req0_b;
  end

  // Next-state logic for the sequencer, counter and response id.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    dp_load = 1'b0;
    dp_en   = 1'b0;
    dp_cin  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          last_d  = grant1;
          id_d    = grant1;
          dp_load = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = grant1 ? req1_sub : req0_sub;
          dp_cin  = sub_d;
`endif
        end
      end
      SHIFT: begin
        dp_en = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; the pointer resets so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

`ifdef SERIAL_ADD_SUB_EN
  assign dp_inv = sub_q;
`else
  assign dp_inv = 1'b0;
`endif

  serial_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (dp_load),
    .enable   (dp_en),
    .cin_init (dp_cin),
    .invert_b (dp_inv),
    .a_in     (dp_a),
    .b_in     (dp_b),
    .result   (rsp_sum),
    .carry    (rsp_cout)
  );

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched: scoreboard bench for serial_add_sched. The driver
// models arbitration and issues expected results into a queue; a monitor
// pops and compares whenever a response is handed over.
module tb_serial_add_sched;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic         req0_sub, req1_sub;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, rsp_id;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic model_busy;
  logic last_m;
  logic acc0, acc1;
  bit   auto_drop;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
`ifdef SERIAL_ADD_SUB_EN
    .req0_sub   (req0_sub),
    .req1_sub   (req1_sub),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic exp_t model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub, input logic id, input int acc);
    exp_t     e;
    int       s;
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
    end else begin
      s      = int'(a) + int'(b);
      e.sum  = s[W-1:0];
      e.cout = (s >= (1 << W));
    end
    e.id  = id;
    e.acc = acc;
    return e;
  endfunction

  task automatic apply_stimulus(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic s0,
                                input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic s1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
  endtask

  // One clock: check readies against the arbitration model, record accepts.
  task automatic tick();
    logic e0, e1, s;
    @(negedge clk);
    acc0 = 1'b0;
    acc1 = 1'b0;
    e0 = !rst && !model_busy && req0_valid && (!req1_valid || last_m);
    e1 = !rst && !model_busy && req1_valid && (!req0_valid || !last_m);
    check_output("req0_ready", 32'(req0_ready), 32'(e0));
    check_output("req1_ready", 32'(req1_ready), 32'(e1));
`ifdef SERIAL_ADD_SUB_EN
    s = e1 ? req1_sub : req0_sub;
`else
    s = 1'b0;
`endif
    if (rst) begin
      model_busy = 1'b0;
      last_m     = 1'b1;
      sb.delete();
    end else if (e0 || e1) begin
      sb.push_back(model_op(e1 ? req1_a : req0_a, e1 ? req1_b : req0_b, s, e1, cyc + 1));
      model_busy = 1'b1;
      last_m     = e1;
      acc0       = e0;
      acc1       = e1;
    end else if (model_busy && rsp_valid && rsp_ready) begin
      model_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    if (auto_drop) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
  endtask

  task automatic wait_accept(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(acc0 || acc1) && n < budget);
    if (!(acc0 || acc1)) check_output("accept_timeout", 32'(n), 32'(0));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((model_busy || sb.size() > 0 || req0_valid || req1_valid) && n < budget) begin
      tick();
      n++;
    end
    if (model_busy || sb.size() > 0) check_output("drain_timeout", 32'(sb.size()), 32'(0));
  endtask

  // Monitor: latency and hold checks, plus scoreboard pop on each handshake.
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_cout, prev_id;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        check_output("rsp_pending", 32'(sb.size()), 32'(1));
        if (sb.size() > 0) check_output("rsp_latency", 32'(cyc - sb[0].acc), 32'(W));
      end
      if (rsp_valid && prev_valid && !prev_ready) begin
        check_output("hold_sum", 32'(rsp_sum), 32'(prev_sum));
        check_output("hold_cout", 32'(rsp_cout), 32'(prev_cout));
        check_output("hold_id", 32'(rsp_id), 32'(prev_id));
      end
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check_output("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        check_output("rsp_cout", 32'(rsp_cout), 32'(e.cout));
        check_output("rsp_id", 32'(rsp_id), 32'(e.id));
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      prev_sum   = rsp_sum;
      prev_cout  = rsp_cout;
      prev_id    = rsp_id;
    end
  end

  initial begin
    rst        = 1'b1;
    rsp_ready  = 1'b0;
    model_busy = 1'b0;
    last_m     = 1'b1;
    auto_drop  = 1'b1;
    apply_stimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    check_output("reset_rsp_sum", 32'(rsp_sum), 32'(0));
    check_output("reset_rsp_cout", 32'(rsp_cout), 32'(0));
    check_output("reset_rsp_id", 32'(rsp_id), 32'(0));
    rst        = 1'b0;
    req0_valid = 1'b0;
    tick();

    $display("[TB] directed adds");
    rsp_ready = 1'b1;
    apply_stimulus(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_accept(20);
    drain(40);
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
    wait_accept(20);
    drain(40);

    $display("[TB] continuous contention");
    auto_drop = 1'b0;
    apply_stimulus(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0);
    for (int k = 0; k < 8; k++) begin
      wait_accept(3 * W);
      check_output("alt_grant", 32'(req1_ready | acc1), 32'(k % 2));
      if (acc0) begin req0_a = W'($urandom); req0_b = W'($urandom); end
      if (acc1) begin req1_a = W'($urandom); req1_b = W'($urandom); end
    end
    auto_drop  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain(40);

    $display("[TB] response back-pressure");
    rsp_ready = 1'b0;
    apply_stimulus(1'b1, 8'hC3, 8'h7E, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_accept(20);
    apply_stimulus(1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
    repeat (W + 6) tick();
    check_output("held_rsp_valid", 32'(rsp_valid), 32'(1));
    rsp_ready = 1'b1;
    drain(80);

    $display("[TB] reset mid-operation");
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h77, 8'h99, 1'b0);
    wait_accept(20);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check_output("midrst_rsp_sum", 32'(rsp_sum), 32'(0));
    check_output("midrst_rsp_cout", 32'(rsp_cout), 32'(0));
    check_output("midrst_rsp_id", 32'(rsp_id), 32'(0));
    apply_stimulus(1'b1, 8'h0F, 8'hF1, 1'b0, 1'b1, 8'h33, 8'h44, 1'b0);
    wait_accept(20);
    check_output("post_reset_winner0", 32'(rsp_id), 32'(0));
    drain(80);

    $display("[TB] randomized traffic");
    auto_drop = 1'b0;
    repeat (500) begin
      apply_stimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    auto_drop  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    drain(80);

`ifdef SERIAL_ADD_SUB_EN
    $display("[TB] subtract mode");
    apply_stimulus(1'b1, 8'h10, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_accept(20);
    drain(40);
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 8'h02, 1'b1);
    wait_accept(20);
    drain(40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Two-requester scheduler for the bit-serial adder datapath. It arbitrates round-robin between two operand sources, loads the winning operands into the serial datapath, and sequences exactly WIDTH shift/add cycles. It then presents sum and carry-out on a valid/ready response port. It sits between the processing elements that need additions and the single shared serial adder, so that only one adder instance is required.

## Interface
- WIDTH, 8, operand/result width and number of serial add cycles (≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_sum  out  WIDTH  a+b modulo 2^WIDTH
- rsp_cout  out  1  carry out of MSB
- rsp_id  out  1  index of requester that issued the operation

## Operation
- FSM states and transitions:
  - IDLE: accepts a request when any reqN_valid is high → SHIFT.
  - SHIFT: runs WIDTH cycles → DONE.
  - DONE: holds the result until rsp_valid&rsp_ready → IDLE.
- Grant in IDLE:
  - Only one valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - Last-grant pointer resets so that req0 wins the first tie.
- reqN_ready = (state==IDLE) & grantN. It may depend combinationally on valids. At most one ready is high per cycle.
- Accept edge:
  - Operands load into the datapath shift registers.
  - Carry register clears.
  - Result register clears.
  - rsp_id captures the winner.
  - Bit counter resets to 0.
- Each SHIFT cycle: the datapath adds LSBs plus held carry, shifts the sum bit in at the result MSB, and updates held carry. The counter increments. At count==WIDTH-1 → DONE.
- DONE:
  - rsp_sum and rsp_cout are stable while rsp_valid is high.
  - The datapath is frozen (enable low).
  - No request is accepted.
- rsp handshake in DONE → IDLE. A new request can be accepted in the following cycle, leaving a one-cycle bubble; there is no bypass.
- Reset values: state IDLE, req*_ready 0 during reset, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, pointer favours req0.
- Reset mid-operation (SHIFT or DONE): the operation is dropped, with no response, and the block returns to IDLE the next cycle.
- Requester valid may drop without acceptance; no state change occurs.

## Timing
- Accept at edge t0; shifts occur at edges t1..tWIDTH; rsp_valid rises after tWIDTH.
- For WIDTH=8: result is visible 8 cycles after the accept edge.
- Back-to-back throughput with rsp_ready held high: one operation per WIDTH+2 cycles.
- rsp_* are registered outputs; there are no combinational paths from inputs to rsp_*.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Adds ports req0_sub and req1_sub (in, 1), sampled at accept.
  - When sub=1, the b operand is bit-inverted serially and the carry register initialises to 1.
  - rsp_sum = a-b mod 2^WIDTH; rsp_cout = 1 means no borrow.
- SERIAL_ADD_SUB_EN undefined: the ports are absent, and carry always initialises to 0.

## Structure
- Package serial_add_pkg: state enum (IDLE, SHIFT, DONE), requester-id type, and the default-width constant.
- Sub-module serial_add_dp holds the datapath:
  - a/b/result shift registers, held carry, full adder
  - inputs: load, enable, cin_init, invert_b
  - outputs: result and carry
- serial_add_sched contains only the FSM, counter, arbiter and response registers.

## Test plan
- req0 a=0x5A b=0x3C, rsp_ready=1 → rsp_valid 8 cycles after accept; sum=0x96, cout=0, id=0.
- req1 a=0xFF b=0x01 → sum=0x00, cout=1, id=1.
- Both valid continuously with distinct operands → grants alternate 0,1,0,1; each response id matches its requester's operands.
- rsp_ready low for 5 cycles in DONE → rsp_valid and sum held; both req*_ready stay 0; IDLE is entered after rsp_ready rises.
- rst asserted at shift cycle 4 → next cycle: IDLE, rsp_valid=0, outputs 0; a new request completes normally.
- With SERIAL_ADD_SUB_EN, sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1; with a=0x01, b=0x02 → sum=0xFF, cout=0.
